// File: rtl/exec_seq_pkg.sv
// Shared definitions for the multi-cycle RV32 sequencer: state encodings and helpers.
package exec_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  // States in which the sequencer stalls on a memory handshake.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/exec_seq_if.sv
// Decoder/memory handshake bundle between the sequencer (master) and the datapath (slave).
// PERF_CNT_EN adds the cycle_cnt / instret_cnt counters to the bundle.
interface exec_seq_if;
  logic        is_load;
  logic        is_store;
  logic        is_halt;
  logic        dec_wren;
  logic        br_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_we;
  logic        dmem_re;
  logic        dmem_we;
  logic        rf_we;
  logic        pc_we;
  logic        pc_sel;
  logic        halted;
  logic        err_timeout;
  logic [2:0]  state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  modport master (
    input  is_load, is_store, is_halt, dec_wren, br_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, pc_sel,
    output halted, err_timeout, state, cycle_cnt, instret_cnt
  );
  modport slave (
    output is_load, is_store, is_halt, dec_wren, br_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, pc_sel,
    input  halted, err_timeout, state, cycle_cnt, instret_cnt
  );
`else
  modport master (
    input  is_load, is_store, is_halt, dec_wren, br_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, pc_sel,
    output halted, err_timeout, state
  );
  modport slave (
    output is_load, is_store, is_halt, dec_wren, br_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, pc_sel,
    input  halted, err_timeout, state
  );
`endif
endinterface

// File: rtl/exec_seq_mem_wdog.sv
// Memory-wait watchdog: expired is asserted during the (2**W-1)-th consecutive wait cycle.
module mem_wdog #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam logic [W-1:0] LAST_BEFORE_MAX = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clear || !waiting) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Fires combinationally so the FSM can leave for HALT in the same cycle the count saturates.
  assign expired = waiting && (cnt_reg == LAST_BEFORE_MAX);

endmodule

// File: rtl/exec_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving all datapath update strobes.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module exec_seq
  import exec_seq_pkg::*;
#(
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_EN_DEF = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  exec_seq_if.master  bus
);

  state_t state_reg, state_next;
  logic   err_reg;
  logic   store_reg;
  logic   waiting, wd_clear, expired;
  logic   imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, pc_sel;

  always_comb begin
    waiting = 1'b0;
    if (TIMEOUT_EN_DEF != 0 && is_wait_state(state_reg)) begin
      waiting = (state_reg == ST_FETCH) ? !bus.imem_ready : !bus.dmem_ready;
    end
  end

  assign wd_clear = (state_next != state_reg);

  mem_wdog #(.W(TIMEOUT_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (waiting),
    .clear   (wd_clear),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
      err_reg   <= 1'b0;
      store_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (expired) err_reg <= 1'b1;
      // Load wins when the decoder flags both, so only a pure store takes the store path.
      if (state_reg == ST_EXECUTE) store_reg <= bus.is_store && !bus.is_load;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: begin
        if (expired)             state_next = ST_HALT;
        else if (bus.imem_ready) state_next = ST_DECODE;
      end
      ST_DECODE:  state_next = bus.is_halt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: state_next = (bus.is_load || bus.is_store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (expired)             state_next = ST_HALT;
        else if (bus.dmem_ready) state_next = store_reg ? ST_FETCH : ST_WB;
      end
      ST_WB:      state_next = ST_FETCH;
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_HALT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    if (rst_n) begin
      case (state_reg)
        ST_FETCH: begin
          imem_req = !expired;
          ir_we    = bus.imem_ready;
        end
        ST_MEM: begin
          if (store_reg) begin
            dmem_we = !expired;
            pc_we   = bus.dmem_ready;
          end else begin
            dmem_re = !expired;
          end
        end
        ST_WB: begin
          rf_we  = bus.dec_wren;
          pc_we  = 1'b1;
          pc_sel = bus.br_taken;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.ir_we       = ir_we;
  assign bus.dmem_re     = dmem_re;
  assign bus.dmem_we     = dmem_we;
  assign bus.rf_we       = rf_we;
  assign bus.pc_we       = pc_we;
  assign bus.pc_sel      = pc_sel;
  assign bus.halted      = (state_reg == ST_HALT);
  assign bus.err_timeout = err_reg;
  assign bus.state       = state_reg;

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_reg, instret_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      if (state_reg != ST_HALT) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (pc_we)                instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end

  assign bus.cycle_cnt   = cycle_cnt_reg;
  assign bus.instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_exec_seq.sv
// Directed bench for exec_seq: per-cycle expected outputs queued as stimulus is driven, checked at negedge.
// Counter checks are compiled in when PERF_CNT_EN is defined.
module tb_exec_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_seq_if bus();

  exec_seq #(.TIMEOUT_W(4), .TIMEOUT_EN_DEF(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [11:0] sb[$];

  // Input vector: {is_load, is_store, is_halt, dec_wren, br_taken, imem_ready, dmem_ready}
  localparam logic [6:0] IN_IDLE  = 7'b0000000;
  localparam logic [6:0] IN_IRDY  = 7'b0000010;
  localparam logic [6:0] IN_ALU   = 7'b0001011;
  localparam logic [6:0] LD_WAIT  = 7'b1001010;
  localparam logic [6:0] LD_GO    = 7'b1001011;
  localparam logic [6:0] ST_WAIT  = 7'b0101010;
  localparam logic [6:0] ST_GO    = 7'b0101011;
  localparam logic [6:0] IN_BR    = 7'b0000111;
  localparam logic [6:0] IN_HALT  = 7'b0010011;

  // Expected vector: {state, halted, err_timeout, imem_req, ir_we, dmem_re, dmem_we, rf_we, pc_we, pc_sel}
  function automatic logic [11:0] ex(input logic [2:0] st, input logic h, input logic er,
                                     input logic rq, input logic ir, input logic re, input logic we,
                                     input logic rf, input logic pw, input logic ps);
    return {st, h, er, rq, ir, re, we, rf, pw, ps};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.state, bus.halted, bus.err_timeout, bus.imem_req, bus.ir_we,
            bus.dmem_re, bus.dmem_we, bus.rf_we, bus.pc_we, bus.pc_sel};
  endfunction

  task automatic drive(input logic rn, input logic [6:0] iv);
    rst_n = rn;
    {bus.is_load, bus.is_store, bus.is_halt, bus.dec_wren,
     bus.br_taken, bus.imem_ready, bus.dmem_ready} = iv;
  endtask

  task automatic idle(input logic rn, input logic [6:0] iv);
    drive(rn, iv);
    @(posedge clk); #1;
  endtask

  task automatic step(input logic rn, input logic [6:0] iv, input logic [11:0] e,
                      input string tag, input bit perf_zero = 1'b0);
    logic [11:0] got, want, mask;
    drive(rn, iv);
    sb.push_back(e);
    @(negedge clk);
    want = sb.pop_front();
    got  = observed();
    mask = want[1] ? 12'hFFF : 12'hFFE;  // pc_sel only meaningful with pc_we
    checks++;
    assert ((got & mask) === (want & mask)) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
`ifdef PERF_CNT_EN
    if (perf_zero) begin
      checks++;
      assert ({bus.cycle_cnt, bus.instret_cnt} === 64'd0) else begin
        failures++;
        $error("FAIL %s_perf: observed=%h/%h expected=0/0", tag, bus.cycle_cnt, bus.instret_cnt);
      end
    end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    drive(1'b0, IN_IDLE);
    @(posedge clk); #1;
    step(0, IN_IDLE, ex(0,0,0,0,0,0,0,0,0,0), "reset");

    // ALU op with zero-wait memories
    step(1, IN_ALU, ex(0,0,0,1,1,0,0,0,0,0), "alu_fetch");
    step(1, IN_ALU, ex(1,0,0,0,0,0,0,0,0,0), "alu_decode");
    step(1, IN_ALU, ex(2,0,0,0,0,0,0,0,0,0), "alu_exec");
    step(1, IN_ALU, ex(4,0,0,0,0,0,0,1,1,0), "alu_wb");

    // Load with dmem_ready delayed 3 cycles
    step(1, LD_WAIT, ex(0,0,0,1,1,0,0,0,0,0), "ld_fetch");
    step(1, LD_WAIT, ex(1,0,0,0,0,0,0,0,0,0), "ld_decode");
    step(1, LD_WAIT, ex(2,0,0,0,0,0,0,0,0,0), "ld_exec");
    for (int i = 0; i < 3; i++)
      step(1, LD_WAIT, ex(3,0,0,0,0,1,0,0,0,0), "ld_mem_wait");
    step(1, LD_GO, ex(3,0,0,0,0,1,0,0,0,0), "ld_mem_done");
    step(1, LD_GO, ex(4,0,0,0,0,0,0,1,1,0), "ld_wb");

    // Store with dmem_ready after 2 cycles
    step(1, ST_WAIT, ex(0,0,0,1,1,0,0,0,0,0), "st_fetch");
    step(1, ST_WAIT, ex(1,0,0,0,0,0,0,0,0,0), "st_decode");
    step(1, ST_WAIT, ex(2,0,0,0,0,0,0,0,0,0), "st_exec");
    for (int i = 0; i < 2; i++)
      step(1, ST_WAIT, ex(3,0,0,0,0,0,1,0,0,0), "st_mem_wait");
    step(1, ST_GO, ex(3,0,0,0,0,0,1,0,1,0), "st_mem_done");

    // Taken branch
    step(1, IN_BR, ex(0,0,0,1,1,0,0,0,0,0), "br_fetch");
    step(1, IN_BR, ex(1,0,0,0,0,0,0,0,0,0), "br_decode");
    step(1, IN_BR, ex(2,0,0,0,0,0,0,0,0,0), "br_exec");
    step(1, IN_BR, ex(4,0,0,0,0,0,0,0,1,1), "br_wb");

    // Halt instruction, then quiet for 20 cycles
    step(1, IN_HALT, ex(0,0,0,1,1,0,0,0,0,0), "halt_fetch");
    step(1, IN_HALT, ex(1,0,0,0,0,0,0,0,0,0), "halt_decode");
    for (int i = 0; i < 20; i++)
      step(1, IN_HALT, ex(5,1,0,0,0,0,0,0,0,0), "halt_hold");

    // Fetch watchdog expiry
    idle(0, IN_IDLE);
    for (int i = 0; i < 14; i++)
      step(1, IN_IDLE, ex(0,0,0,1,0,0,0,0,0,0), "to_wait");
    step(1, IN_IDLE, ex(0,0,0,0,0,0,0,0,0,0), "to_expire");
    step(1, IN_IDLE, ex(5,1,1,0,0,0,0,0,0,0), "to_halt");

    // Ready rising in the expiry cycle wins
    idle(0, IN_IDLE);
    for (int i = 0; i < 14; i++)
      step(1, IN_IDLE, ex(0,0,0,1,0,0,0,0,0,0), "race_wait");
    step(1, IN_IRDY, ex(0,0,0,1,1,0,0,0,0,0), "race_ready");
    step(1, IN_IDLE, ex(1,0,0,0,0,0,0,0,0,0), "race_decode");

    // Reset during a pending load wait
    idle(0, IN_IDLE);
    step(1, LD_WAIT, ex(0,0,0,1,1,0,0,0,0,0), "rm_fetch");
    step(1, LD_WAIT, ex(1,0,0,0,0,0,0,0,0,0), "rm_decode");
    step(1, LD_WAIT, ex(2,0,0,0,0,0,0,0,0,0), "rm_exec");
    step(1, LD_WAIT, ex(3,0,0,0,0,1,0,0,0,0), "rm_mem_wait");
    step(1, LD_WAIT, ex(3,0,0,0,0,1,0,0,0,0), "rm_mem_wait");
    step(0, LD_WAIT, ex(3,0,0,0,0,0,0,0,0,0), "rm_reset_cycle");
    step(1, IN_IDLE, ex(0,0,0,1,0,0,0,0,0,0), "rm_refetch", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
